input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the stable-input cycles needed before a clean output changes (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter BUTTON_ACTIVE_LOW, default 1; when 1, raw button bits are inverted after synchronisation so that 1 means pressed.
REQ-003 SHALL have port clk_clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port reset_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port button_raw, input, 4 bits: asynchronous push-button pins.
REQ-006 SHALL have port switch_raw, input, 10 bits: asynchronous slide-switch pins.
REQ-007 SHALL have port button_clean, output, 4 bits: debounced button level, 1 = pressed; it feeds the system's button PIO input.
REQ-008 SHALL have port switch_clean, output, 10 bits: debounced switch level; it feeds the system's switch PIO input.
REQ-009 SHALL have port button_press, output, 4 bits: a one-cycle pulse on each 0->1 transition of button_clean.
REQ-010 SHALL have port switch_change, output, 1 bit: a one-cycle pulse whenever any switch_clean bit changes.

Function
REQ-011 Each of the 14 input bits SHALL pass through a two-flop synchronizer; call the second flop's output sync.
REQ-012 Each bit SHALL own a counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 When sync equals the bit's clean value, its counter SHALL be 0 on the next edge.
REQ-014 When sync differs from the clean value and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-015 When sync differs from the clean value and the counter equals DEBOUNCE_CYCLES-1, clean SHALL load sync and the counter SHALL return to 0 on the same edge.
REQ-016 Latency: a raw change held stable SHALL appear on clean exactly 2+DEBOUNCE_CYCLES edges after the first edge that samples it.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles at sync SHALL leave clean unchanged and SHALL restart qualification from 0.
REQ-018 button_press[i] SHALL assert for exactly one cycle, on the cycle after button_clean[i] rises; a release SHALL produce no pulse.
REQ-019 Several bits qualifying on the same edge SHALL each update independently; simultaneous presses SHALL pulse together in one cycle.
REQ-020 switch_change SHALL be the registered OR of all switch bits that update on an edge; it pulses once even when several switches change together.

Reset
REQ-021 While reset_reset_n = 0 at a clk_clk edge, the following SHALL be loaded:
- synchronizer flops: the released level (1 for buttons when BUTTON_ACTIVE_LOW=1, else 0; 0 for switches);
- all counters: 0;
- button_clean and switch_clean: 0;
- button_press and switch_change: 0.
REQ-022 A reset asserted mid-qualification SHALL abandon the count.
REQ-023 After reset deasserts, a switch already high SHALL require the full 2+DEBOUNCE_CYCLES latency before it appears on switch_clean, and SHALL then produce one switch_change pulse.

Configuration
REQ-024 Macro INPUT_COND_EDGE_EN SHALL control the event-pulse logic.
- Defined: the button_press and switch_change logic is compiled in.
- Undefined: both outputs are tied to constant 0, the edge registers are absent, and the debounce behaviour is unchanged.

Structure
REQ-025 Package input_cond_pkg SHALL hold N_BUTTONS=4, N_SWITCHES=10 and the default debounce constant.
REQ-026 A single-bit sub-module debounce_bit SHALL contain the synchronizer, counter and clean register; it SHALL be instantiated 14 times through generate loops.

Verification (DEBOUNCE_CYCLES=4, BUTTON_ACTIVE_LOW=1, INPUT_COND_EDGE_EN defined)
REQ-027 button_raw 4'hF -> 4'hE held -> button_clean = 4'h1 at edge 6, button_press = 4'h1 for one cycle after it; release -> no pulse.
REQ-028 switch_raw bit 3 pulsed high for 3 cycles -> switch_clean stays 10'h000 and switch_change stays 0.
REQ-029 switch_raw 10'h000 -> 10'h2A5 in one cycle -> switch_clean = 10'h2A5 after 6 edges, exactly one switch_change pulse.
REQ-030 Raw bounce 1,0,1,0 then stable 0 on button 2 -> a single clean rise 6 edges after the last bounce, a single press pulse.
REQ-031 reset_reset_n low for 1 cycle at counter=2 during qualification -> all outputs 0, full 6-edge qualification restarts.
REQ-032 Rebuild without INPUT_COND_EDGE_EN and rerun REQ-027 -> identical button_clean, button_press constantly 0.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
// Shared constants for the push-button / slide-switch conditioner.
//   N_BUTTONS        : number of push-button inputs
//   N_SWITCHES       : number of slide-switch inputs
//   DEBOUNCE_DEFAULT : default qualification time in clock cycles
//                      (10 ms at 50 MHz)
// -----------------------------------------------------------------------------
package input_cond_pkg;
    localparam int N_BUTTONS        = 4;
    localparam int N_SWITCHES       = 10;
    localparam int DEBOUNCE_DEFAULT = 500000;
endpackage

// File: rtl/input_conditioner_debounce.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Single-bit conditioner: two-flop synchronizer, qualification counter and
// clean-level register.
//   Parameters : CYCLES   - stable cycles needed before clean follows sync
//                INVERT   - invert the synchronized level before comparing
//                SYNC_RST - level loaded into the synchronizer on reset
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   raw_i      : asynchronous pin
//   clean_o    : debounced level (reset value 0)
// -----------------------------------------------------------------------------
module debounce_bit #(
    parameter int CYCLES   = 4,
    parameter bit INVERT   = 1'b0,
    parameter bit SYNC_RST = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic clean_o
);
    localparam int             CW       = $clog2(CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          lvl;

    // Polarity is fixed after the synchronizer so the flops hold pin level.
    assign lvl = sync2_q ^ INVERT;

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (lvl == clean_q) begin
            // Any return to the current clean level restarts qualification.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = lvl;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;
endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Debounces the board push-buttons and slide-switches and derives event pulses.
//   clk_clk       : single clock
//   reset_reset_n : synchronous active-low reset
//   button_raw    : asynchronous button pins
//   switch_raw    : asynchronous switch pins
//   button_clean  : debounced button level, 1 = pressed
//   switch_clean  : debounced switch level
//   button_press  : one-cycle pulse, cycle after a button_clean bit rises
//   switch_change : one-cycle pulse, cycle after any switch_clean bit changes
// Macro INPUT_COND_EDGE_EN: when defined the pulse logic is built; otherwise
// button_press and switch_change are constant 0.
// -----------------------------------------------------------------------------
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [N_BUTTONS-1:0]  button_raw,
    input  logic [N_SWITCHES-1:0] switch_raw,
    output logic [N_BUTTONS-1:0]  button_clean,
    output logic [N_SWITCHES-1:0] switch_clean,
    output logic [N_BUTTONS-1:0]  button_press,
    output logic                  switch_change
);
    // Buttons: synchronizer idles at the released pin level so reset does not
    // look like a press.
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        debounce_bit #(
            .CYCLES  (DEBOUNCE_CYCLES),
            .INVERT  (BUTTON_ACTIVE_LOW),
            .SYNC_RST(BUTTON_ACTIVE_LOW)
        ) u_db (
            .clk_i  (clk_clk),
            .rst_ni (reset_reset_n),
            .raw_i  (button_raw[i]),
            .clean_o(button_clean[i])
        );
    end

    for (genvar i = 0; i < N_SWITCHES; i++) begin : g_sw
        debounce_bit #(
            .CYCLES  (DEBOUNCE_CYCLES),
            .INVERT  (1'b0),
            .SYNC_RST(1'b0)
        ) u_db (
            .clk_i  (clk_clk),
            .rst_ni (reset_reset_n),
            .raw_i  (switch_raw[i]),
            .clean_o(switch_clean[i])
        );
    end

`ifdef INPUT_COND_EDGE_EN
    logic [N_BUTTONS-1:0]  btn_prev_q;
    logic [N_SWITCHES-1:0] sw_prev_q;
    logic [N_BUTTONS-1:0]  press_q, press_d;
    logic                  change_q, change_d;

    // Edges are taken against a delayed copy of the clean levels, so the
    // pulse lands on the cycle after the clean output moves.
    assign press_d  = button_clean & ~btn_prev_q;
    assign change_d = |(switch_clean ^ sw_prev_q);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            btn_prev_q <= '0;
            sw_prev_q  <= '0;
            press_q    <= '0;
            change_q   <= 1'b0;
        end else begin
            btn_prev_q <= button_clean;
            sw_prev_q  <= switch_clean;
            press_q    <= press_d;
            change_q   <= change_d;
        end
    end

    assign button_press  = press_q;
    assign switch_change = change_q;
`else
    assign button_press  = '0;
    assign switch_change = 1'b0;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Randomized plus directed stimulus against a history-window reference model:
// a bit's clean level takes value v when its last DEBOUNCE_CYCLES synchronized
// samples all equal v and v differs from the current clean level.
// -----------------------------------------------------------------------------
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int D   = 4;
    localparam bit BAL = 1'b1;
`ifdef INPUT_COND_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic                  clk_clk = 1'b0;
    logic                  reset_reset_n = 1'b0;
    logic [N_BUTTONS-1:0]  button_raw = 4'hF;
    logic [N_SWITCHES-1:0] switch_raw = '0;
    logic [N_BUTTONS-1:0]  button_clean, button_press;
    logic [N_SWITCHES-1:0] switch_clean;
    logic                  switch_change;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .BUTTON_ACTIVE_LOW(BAL)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .button_raw   (button_raw),
        .switch_raw   (switch_raw),
        .button_clean (button_clean),
        .switch_clean (switch_clean),
        .button_press (button_press),
        .switch_change(switch_change)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [3:0] bc;
        logic [9:0] sc;
        logic [3:0] bp;
        logic       ch;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0, n_bad = 0, sc_pulses = 0, bp_pulses = 0;

    // Reference model state: raw-sample history (index 0 = newest) and levels.
    logic [3:0] hb [0:D];
    logic [9:0] hs [0:D];
    logic [3:0] m_bc, m_bprev;
    logic [9:0] m_sc, m_sprev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        exp_t       e;
        logic [3:0] nbc, nbp;
        logic [9:0] nsc;
        logic       nch;
        if (!reset_reset_n) begin
            for (int j = 0; j <= D; j++) begin
                hb[j] = BAL ? 4'hF : 4'h0;
                hs[j] = '0;
            end
            m_bc = '0; m_sc = '0; m_bprev = '0; m_sprev = '0;
            nbp = '0; nch = 1'b0;
        end else begin
            nbp = m_bc & ~m_bprev;
            nch = |(m_sc ^ m_sprev);
            m_bprev = m_bc;
            m_sprev = m_sc;
            nbc = m_bc;
            nsc = m_sc;
            // Synchronized value seen at this edge is the raw sample from two
            // edges earlier, i.e. hb[1]; the window is hb[1..D].
            for (int i = 0; i < 4; i++) begin
                logic v; bit same;
                v = hb[1][i]; same = 1'b1;
                for (int j = 2; j <= D; j++) if (hb[j][i] !== v) same = 1'b0;
                if (same && ((v ^ BAL) !== m_bc[i])) nbc[i] = v ^ BAL;
            end
            for (int i = 0; i < 10; i++) begin
                logic v; bit same;
                v = hs[1][i]; same = 1'b1;
                for (int j = 2; j <= D; j++) if (hs[j][i] !== v) same = 1'b0;
                if (same && (v !== m_sc[i])) nsc[i] = v;
            end
            m_bc = nbc;
            m_sc = nsc;
            for (int j = D; j > 0; j--) begin
                hb[j] = hb[j-1];
                hs[j] = hs[j-1];
            end
            hb[0] = button_raw;
            hs[0] = switch_raw;
        end
        e.bc = m_bc;
        e.sc = m_sc;
        e.bp = EDGE ? nbp : 4'h0;
        e.ch = EDGE ? nch : 1'b0;
        exp_q.push_back(e);
    endtask

    // Scoreboard producer: one expected output set per clock edge.
    initial forever begin
        @(posedge clk_clk);
        model_step();
    end

    // Monitor: compares DUT outputs away from the active edge.
    initial forever begin
        @(negedge clk_clk);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("button_clean",  32'(button_clean),  32'(mon_e.bc));
            chk("switch_clean",  32'(switch_clean),  32'(mon_e.sc));
            chk("button_press",  32'(button_press),  32'(mon_e.bp));
            chk("switch_change", 32'(switch_change), 32'(mon_e.ch));
            if (switch_change === 1'b1) sc_pulses++;
            if (button_press !== 4'h0) bp_pulses++;
        end
    end

    task automatic apply(input logic [3:0] b, input logic [9:0] s, input int n);
        button_raw = b;
        switch_raw = s;
        repeat (n) @(posedge clk_clk);
        #2;
    endtask

    task automatic pulse_reset(input int n);
        reset_reset_n = 1'b0;
        repeat (n) @(posedge clk_clk);
        #2;
        reset_reset_n = 1'b1;
    endtask

    initial begin
        int p0;
        logic [3:0] rb;
        logic [9:0] rs;
        // Reset.
        repeat (3) @(posedge clk_clk);
        #2;
        chk("reset button_clean", 32'(button_clean), 32'h0);
        chk("reset switch_clean", 32'(switch_clean), 32'h0);
        reset_reset_n = 1'b1;
        apply(4'hF, '0, 4);

        // Press button 0: clean rises at edge 6, press pulses once; release.
        p0 = bp_pulses;
        apply(4'hE, '0, 5);
        chk("btn0 not yet clean", 32'(button_clean), 32'h0);
        apply(4'hE, '0, 1);
        chk("btn0 clean at edge 6", 32'(button_clean), 32'h1);
        apply(4'hE, '0, 6);
        apply(4'hF, '0, 10);
        chk("btn0 released", 32'(button_clean), 32'h0);
        chk("btn0 press pulses", 32'(bp_pulses - p0), EDGE ? 32'd1 : 32'd0);

        // Short switch glitch is rejected.
        p0 = sc_pulses;
        apply(4'hF, 10'h008, 3);
        apply(4'hF, 10'h000, 10);
        chk("glitch switch_clean", 32'(switch_clean), 32'h0);
        chk("glitch no change", 32'(sc_pulses - p0), 32'd0);

        // Multi-switch change: one pulse.
        p0 = sc_pulses;
        apply(4'hF, 10'h2A5, 6);
        chk("sw 2A5 at edge 6", 32'(switch_clean), 32'h2A5);
        apply(4'hF, 10'h2A5, 6);
        chk("sw change pulses", 32'(sc_pulses - p0), EDGE ? 32'd1 : 32'd0);
        apply(4'hF, 10'h000, 10);

        // Bounce on button 2 (pin 1,0,1,0 then held 0).
        p0 = bp_pulses;
        apply(4'hF, '0, 1);
        apply(4'hB, '0, 1);
        apply(4'hF, '0, 1);
        apply(4'hB, '0, 5);
        chk("bounce not early", 32'(button_clean), 32'h0);
        apply(4'hB, '0, 1);
        chk("bounce clean rise", 32'(button_clean), 32'h4);
        apply(4'hB, '0, 6);
        chk("bounce one press", 32'(bp_pulses - p0), EDGE ? 32'd1 : 32'd0);
        apply(4'hF, '0, 10);

        // Reset mid-qualification abandons the count.
        apply(4'hF, 10'h001, 4);
        pulse_reset(1);
        chk("mid reset switch_clean", 32'(switch_clean), 32'h0);
        apply(4'hF, 10'h001, 5);
        chk("requal not early", 32'(switch_clean), 32'h0);
        apply(4'hF, 10'h001, 1);
        chk("requal at edge 6", 32'(switch_clean), 32'h1);
        apply(4'hF, 10'h000, 10);

        // Switches already high when reset releases.
        switch_raw = 10'h3FF;
        pulse_reset(2);
        p0 = sc_pulses;
        apply(4'hF, 10'h3FF, 12);
        chk("post-reset switches", 32'(switch_clean), 32'h3FF);
        chk("post-reset one change", 32'(sc_pulses - p0), EDGE ? 32'd1 : 32'd0);

        // Randomized segment, occasional reset.
        for (int k = 0; k < 150; k++) begin
            rb = 4'($urandom);
            rs = 10'($urandom);
            if ($urandom_range(0, 24) == 0) pulse_reset(1);
            apply(rb, rs, $urandom_range(1, 8));
        end
        apply(4'hF, '0, 10);

        @(negedge clk_clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
